// File: rtl/up_dwn_cntr_gen.sv
// Parametrised up/down counter: range MIN_VAL..MAX_VAL, configurable step, clamped load,
// wrap/saturate mode and a boundary pulse. Optional enable prescaler: CNTR_PRESCALE_EN.
module up_dwn_cntr_gen #(
  parameter int unsigned     WIDTH    = 8,
  parameter longint unsigned MIN_VAL  = 0,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned     STEP     = 1,
  parameter int unsigned     PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dwn_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] cnt,
  output logic             bnd,
  output logic             at_max,
  output logic             at_min
);

  // One extra bit of headroom so cnt+STEP and MIN_VAL+STEP never wrap silently
  localparam logic [WIDTH:0]   MINV  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAXV  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEPV = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MINW  = MINV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MAXW  = MAXV[WIDTH-1:0];

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             bnd_q, bnd_d;
  logic             tick;
  logic [WIDTH:0]   cnt_ext, ld_ext, up_sum, dn_lim;

`ifdef CNTR_PRESCALE_EN
  localparam int unsigned    PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;

  assign tick = (pre_q == PLAST);

  always_ff @(posedge clk) begin
    if (rst || ld) begin
      pre_q <= '0;
    end else if (en) begin
      if (tick) pre_q <= '0;
      else      pre_q <= pre_q + PW'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    bnd_d   = 1'b0;
    cnt_ext = {1'b0, cnt_q};
    ld_ext  = {1'b0, ld_val};
    up_sum  = cnt_ext + STEPV;
    dn_lim  = MINV + STEPV;
    if (ld) begin
      if (ld_ext < MINV)      cnt_d = MINW;
      else if (ld_ext > MAXV) cnt_d = MAXW;
      else                    cnt_d = ld_val;
    end else if (en && tick) begin
      if (up_dwn_n) begin
        if (up_sum <= MAXV) begin
          cnt_d = up_sum[WIDTH-1:0];
        end else begin
          cnt_d = sat_mode ? MAXW : MINW;
          bnd_d = 1'b1;
        end
      end else begin
        if (cnt_ext >= dn_lim) begin
          cnt_d = cnt_q - STEPV[WIDTH-1:0];
        end else begin
          cnt_d = sat_mode ? MINW : MAXW;
          bnd_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= MINW;
      bnd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      bnd_q <= bnd_d;
    end
  end

  assign cnt    = cnt_q;
  assign bnd    = bnd_q;
  assign at_max = (cnt_q == MAXW);
  assign at_min = (cnt_q == MINW);

endmodule
